// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side register hazard tracker.
//
// Long-latency writers (loads, multi-cycle mul/div) leaving ID load a
// per-register countdown with their latency. While a count is non-zero
// the register is busy, and an ID instruction that reads it is stalled.
// Bypass logic in EX covers every hazard that is not tracked here.
//
// Optional feature: define SCOREBOARD_STALL_CNT_EN to build a 32-bit
// counter of stalled cycles on o_stall_cycles. Without the macro the
// counter is not built and o_stall_cycles is tied to zero.
//
// Handshake: an issue is taken only when i_issue_valid is high and o_stall
// is low in the same cycle. An issue presented while stalled is dropped,
// and it is never held or replayed. Upstream sends a bubble in that case,
// but this block does not depend on that.

module reg_scoreboard #(
    parameter int LAT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    input  logic             i_issue_regwrite,
    input  logic [4:0]       i_issue_rd,
    input  logic [LAT_W-1:0] i_issue_lat,
    input  logic             i_flush,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    output logic             o_stall,
    output logic [31:0]      o_busy_vec,
    output logic [31:0]      o_stall_cycles
);

    // Countdown per architectural register. x0 has no entry.
    logic [LAT_W-1:0] r_cnt [1:31];

    logic [31:0] w_busy;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_stall;
    logic        w_accept;

    // Busy bits come only from registered counts. x0 is hard-wired to not busy.
    always_comb begin
        w_busy    = '0;
        w_busy[0] = 1'b0;
        for (int i = 1; i < 32; i++) begin
            w_busy[i] = (r_cnt[i] != '0);
        end
    end

    // Stall looks only at ID sources and registered state, never at issue_*.
    always_comb begin
        w_rs1_hit = i_id_rs1_used & (i_id_rs1 != 5'd0) & w_busy[i_id_rs1];
        w_rs2_hit = i_id_rs2_used & (i_id_rs2 != 5'd0) & w_busy[i_id_rs2];
        w_stall   = w_rs1_hit | w_rs2_hit;
    end

    // An issue is tracked only if it writes a real register with a non-zero latency.
    always_comb begin
        w_accept = i_issue_valid & i_issue_regwrite & (i_issue_rd != 5'd0) &
                   (i_issue_lat != '0) & ~w_stall & ~i_flush;
    end

    // Countdown update: reset, then flush, then a new issue (overwrites on WAW), then saturating decrement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_accept && (i_issue_rd == 5'(i))) begin
                    r_cnt[i] <= i_issue_lat;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - LAT_W'(1);
                end
            end
        end
    end

    assign o_stall    = w_stall;
    assign o_busy_vec = w_busy;

`ifdef SCOREBOARD_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // Count every stalled cycle. The count wraps naturally and survives flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard. Inputs are driven 1 ns after each
// rising edge, and outputs are checked at that point. The results are then
// stable, because they depend on the new inputs and on the state latched at
// that edge.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_STALL_CNT_EN
    localparam int SC_EN = 1;
`else
    localparam int SC_EN = 0;
`endif

    localparam int LAT_W = 3;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic             issue_regwrite;
    logic [4:0]       issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic             flush;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             stall;
    logic [31:0]      busy_vec;
    logic [31:0]      stall_cycles;

    int n_checks;
    int n_errors;

    reg_scoreboard #(.LAT_W(LAT_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_issue_valid    (issue_valid),
        .i_issue_regwrite (issue_regwrite),
        .i_issue_rd       (issue_rd),
        .i_issue_lat      (issue_lat),
        .i_flush          (flush),
        .i_id_rs1         (id_rs1),
        .i_id_rs2         (id_rs2),
        .i_id_rs1_used    (id_rs1_used),
        .i_id_rs2_used    (id_rs2_used),
        .o_stall          (stall),
        .o_busy_vec       (busy_vec),
        .o_stall_cycles   (stall_cycles)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        issue_valid    = 1'b0;
        issue_regwrite = 1'b0;
        issue_rd       = 5'd0;
        issue_lat      = '0;
        flush          = 1'b0;
        id_rs1         = 5'd0;
        id_rs2         = 5'd0;
        id_rs1_used    = 1'b0;
        id_rs2_used    = 1'b0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        issue_valid    = 1'b1;
        issue_regwrite = 1'b1;
        issue_rd       = rd;
        issue_lat      = lat;
    endtask

    task automatic clear_issue();
        issue_valid    = 1'b0;
        issue_regwrite = 1'b0;
        issue_rd       = 5'd0;
        issue_lat      = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (busy_vec !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_busy cycle %0d: got %h expected 0", k, busy_vec);
            end
            n_checks++;
            if (stall !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_stall cycle %0d: got %b expected 0", k, stall);
            end
            n_checks++;
            if (stall_cycles !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_stall_cycles cycle %0d: got %0d expected 0", k, stall_cycles);
            end
            step();
        end
    endtask

    task automatic test_basic_stall();
        logic [31:0] exp_sc;
        do_reset();
        drive_issue(5'd5, 3'd2);
        id_rs1      = 5'd5;
        id_rs1_used = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_same_cycle_stall: got %b expected 0", stall);
        end
        step();
        clear_issue();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (stall !== (k < 2)) begin
                n_errors++;
                $display("FAIL basic_stall cycle %0d: got %b expected %b", k, stall, (k < 2));
            end
            n_checks++;
            if (busy_vec !== ((k < 2) ? 32'h0000_0020 : 32'h0)) begin
                n_errors++;
                $display("FAIL basic_busy cycle %0d: got %h", k, busy_vec);
            end
            if (k < 2) step();
        end
        exp_sc = (SC_EN != 0) ? 32'd2 : 32'd0;
        n_checks++;
        if (stall_cycles !== exp_sc) begin
            n_errors++;
            $display("FAIL basic_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_untracked();
        do_reset();
        id_rs1      = 5'd0;
        id_rs1_used = 1'b1;
        id_rs2      = 5'd7;
        id_rs2_used = 1'b1;
        drive_issue(5'd0, 3'd3);
        step();
        drive_issue(5'd7, 3'd0);
        step();
        clear_issue();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (busy_vec !== 32'd0 || stall !== 1'b0) begin
                n_errors++;
                $display("FAIL untracked cycle %0d: busy %h stall %b expected 0/0", k, busy_vec, stall);
            end
            step();
        end
    endtask

    task automatic test_waw();
        logic [31:0] exp_b [4];
        exp_b[0] = 32'h200; exp_b[1] = 32'h200; exp_b[2] = 32'h0; exp_b[3] = 32'h0;
        do_reset();
        drive_issue(5'd9, 3'd3);
        step();
        n_checks++;
        if (busy_vec !== exp_b[0]) begin
            n_errors++;
            $display("FAIL waw_first: got %h expected %h", busy_vec, exp_b[0]);
        end
        drive_issue(5'd9, 3'd1);
        step();
        clear_issue();
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (busy_vec !== exp_b[k]) begin
                n_errors++;
                $display("FAIL waw cycle %0d: got %h expected %h", k, busy_vec, exp_b[k]);
            end
            step();
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_issue(5'd4, 3'd5);
        step();
        clear_issue();
        n_checks++;
        if (busy_vec !== 32'h10) begin
            n_errors++;
            $display("FAIL flush_pre: got %h expected 00000010", busy_vec);
        end
        step();
        flush = 1'b1;
        drive_issue(5'd6, 3'd2);
        step();
        flush = 1'b0;
        clear_issue();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec !== 32'd0) begin
                n_errors++;
                $display("FAIL flush_clear cycle %0d: got %h expected 0", k, busy_vec);
            end
            step();
        end
    endtask

    task automatic test_stalled_issue();
        logic [31:0] exp_sc;
        do_reset();
        drive_issue(5'd3, 3'd4);
        step();
        id_rs2      = 5'd3;
        id_rs2_used = 1'b1;
        drive_issue(5'd8, 3'd2);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL stalled_rs2: got %b expected 1", stall);
        end
        step();
        n_checks++;
        if (busy_vec !== 32'h8 || stall !== 1'b1) begin
            n_errors++;
            $display("FAIL stalled_issue c2: busy %h stall %b expected 00000008/1", busy_vec, stall);
        end
        step();
        clear_issue();
        n_checks++;
        if (busy_vec !== 32'h8) begin
            n_errors++;
            $display("FAIL stalled_issue c3: busy %h expected 00000008", busy_vec);
        end
        exp_sc = (SC_EN != 0) ? 32'd2 : 32'd0;
        n_checks++;
        if (stall_cycles !== exp_sc) begin
            n_errors++;
            $display("FAIL stalled_cycles: got %0d expected %0d", stall_cycles, exp_sc);
        end
        id_rs2_used = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL unused_rs2: got %b expected 0", stall);
        end
        // A flush must not clear the stall counter.
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (stall_cycles !== exp_sc || busy_vec !== 32'd0) begin
            n_errors++;
            $display("FAIL flush_keeps_cnt: cnt %0d busy %h expected %0d/0", stall_cycles, busy_vec, exp_sc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_b [4];
        exp_b[0] = 32'h2; exp_b[1] = 32'h4; exp_b[2] = 32'h4; exp_b[3] = 32'h0;
        do_reset();
        drive_issue(5'd1, 3'd1);
        step();
        drive_issue(5'd2, 3'd2);
        id_rs1      = 5'd1;
        id_rs1_used = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_rs1_stall: got %b expected 1", stall);
        end
        id_rs1_used = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (busy_vec !== exp_b[k]) begin
                n_errors++;
                $display("FAIL b2b cycle %0d: got %h expected %h", k, busy_vec, exp_b[k]);
            end
            step();
            clear_issue();
        end
    endtask

    task automatic test_max_lat();
        do_reset();
        drive_issue(5'd31, 3'd7);
        step();
        clear_issue();
        id_rs2      = 5'd31;
        id_rs2_used = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (busy_vec[31] !== (k < 7) || stall !== (k < 7)) begin
                n_errors++;
                $display("FAIL max_lat cycle %0d: busy31 %b stall %b expected %b", k, busy_vec[31], stall, (k < 7));
            end
            step();
        end
        // Reset in the middle of a countdown drops the pending write.
        drive_issue(5'd10, 3'd7);
        step();
        clear_issue();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (busy_vec !== 32'd0 || stall_cycles !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid: busy %h cnt %0d expected 0/0", busy_vec, stall_cycles);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        set_idle();
        step();
        test_reset();
        test_basic_stall();
        test_untracked();
        test_waw();
        test_flush();
        test_stalled_issue();
        test_back_to_back();
        test_max_lat();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
